// File: rtl/fft_out_collector_pkg.sv
// Shared fft definitions: sample geometry, complex sample layout, bit-reversal helper.
package fft_out_collector_pkg;

    localparam int FFT_RE_W     = 17;
    localparam int FFT_IM_W     = 17;
    localparam int FFT_SAMPLE_W = FFT_RE_W + FFT_IM_W;
    localparam int FFT_N_PT     = 4;

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [FFT_RE_W-1:0] re;
        logic signed [FFT_IM_W-1:0] im;
    } sample_t;

    // Reverses the low log2n bits of idx; upper bits come back zero.
    function automatic logic [7:0] bitrev(input logic [7:0] idx, input int log2n);
        logic [7:0] r;
        r = '0;
        for (int b = 0; b < log2n; b++) begin
            r[b] = idx[log2n-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_collector_if.sv
// Serial sample input plus frame-wide valid/ready output of the fft output collector.
interface fft_out_collector_if
    import fft_out_collector_pkg::*;
#(
    parameter int N_PT     = FFT_N_PT,
    parameter int SAMPLE_W = FFT_SAMPLE_W
);
    logic                     in_valid;
    logic                     in_sof;
    logic [SAMPLE_W-1:0]      in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [N_PT*SAMPLE_W-1:0] out_frame;
    logic                     sync_err;
    logic                     overflow;

    modport master (
        output in_valid, in_sof, in_data, out_ready,
        input  out_valid, out_frame, sync_err, overflow
    );

    modport slave (
        input  in_valid, in_sof, in_data, out_ready,
        output out_valid, out_frame, sync_err, overflow
    );
endinterface

// File: rtl/fft_out_collector_frame_bank.sv
// One N_PT x SAMPLE_W frame register bank with per-slot write and a full flag.
// Latency: slot write and full flag visible the cycle after the write edge.
// Backpressure: none internally; the caller must not write while full is set.
module fft_out_collector_frame_bank #(
    parameter int N_PT     = 4,
    parameter int SAMPLE_W = 34,
    localparam int IDX_W   = $clog2(N_PT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_slot,
    input  logic [SAMPLE_W-1:0]      wr_data,
    input  logic                     set_full,
    input  logic                     clr_full,
    output logic [N_PT*SAMPLE_W-1:0] data,
    output logic                     full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            full <= 1'b0;
        end else begin
            if (wr_en) begin
                for (int s = 0; s < N_PT; s++) begin
                    if (wr_slot == IDX_W'(s)) begin
                        data[s*SAMPLE_W +: SAMPLE_W] <= wr_data;
                    end
                end
            end
            if (set_full) begin
                full <= 1'b1;
            end else if (clr_full) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fft_out_collector.sv
// Collects serial fft samples into bit-reversal-corrected frames, ping-pong buffered.
// Latency: out_valid rises one cycle after the frame's last sample is written.
// Backpressure: out_ready low holds the frame; a sample arriving with both banks full is dropped (overflow).
module fft_out_collector
    import fft_out_collector_pkg::*;
#(
    parameter int N_PT     = FFT_N_PT,
    parameter int SAMPLE_W = FFT_SAMPLE_W,
    parameter bit BITREV   = 1'b1
) (
    input logic          clk,
    input logic          rst,
    fft_out_collector_if.slave bus
);

    localparam int IDX_W = $clog2(N_PT);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PT - 1);

    state_t                   st;
    logic [IDX_W-1:0]         idx;
    logic                     wr_bank;
    logic                     rd_bank;
    logic                     out_valid_q;
    logic [N_PT*SAMPLE_W-1:0] out_frame_q;
    logic                     sync_err_q;
    logic                     overflow_q;

    logic [1:0]               full;
    logic [N_PT*SAMPLE_W-1:0] bank_data [2];

    logic                     take;
    logic                     blocked;
    logic                     wr_en;
    logic                     frame_done;
    logic                     handshake;
    logic [IDX_W-1:0]         wr_idx;
    logic [IDX_W-1:0]         slot;

    // Full status is the pre-edge value, so a bank freed this cycle still blocks a write into it.
    always_comb begin
        take       = bus.in_valid && (bus.in_sof || st == ST_COLLECT);
        blocked    = take && full[wr_bank];
        wr_en      = take && !full[wr_bank];
        wr_idx     = bus.in_sof ? '0 : idx;
        frame_done = wr_en && (wr_idx == LAST);
        handshake  = out_valid_q && bus.out_ready;
        slot       = BITREV ? IDX_W'(bitrev(8'(wr_idx), IDX_W)) : wr_idx;
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_out_collector_frame_bank #(
            .N_PT     (N_PT),
            .SAMPLE_W (SAMPLE_W)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en && (wr_bank == 1'(g))),
            .wr_slot  (slot),
            .wr_data  (bus.in_data),
            .set_full (frame_done && (wr_bank == 1'(g))),
            .clr_full (handshake && (rd_bank == 1'(g))),
            .data     (bank_data[g]),
            .full     (full[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= ST_HUNT;
            idx         <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            out_valid_q <= 1'b0;
            out_frame_q <= '0;
            sync_err_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync_err_q <= 1'b0;
            if (blocked) begin
                overflow_q <= 1'b1;
                st         <= ST_HUNT;
                idx        <= '0;
            end else if (wr_en) begin
                st <= ST_COLLECT;
                if (bus.in_sof && st == ST_COLLECT && idx != '0) begin
                    sync_err_q <= 1'b1;
                end
                if (wr_idx == LAST) begin
                    idx     <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    idx <= wr_idx + 1'b1;
                end
            end

            // On handoff the other bank, if already full, is presented without a bubble.
            if (handshake) begin
                rd_bank <= ~rd_bank;
                if (full[~rd_bank]) begin
                    out_valid_q <= 1'b1;
                    out_frame_q <= bank_data[~rd_bank];
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (!out_valid_q && full[rd_bank]) begin
                out_valid_q <= 1'b1;
                out_frame_q <= bank_data[rd_bank];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_frame = out_frame_q;
    assign bus.sync_err  = sync_err_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fft_out_collector.sv
// Scoreboard bench: a bit-reversing and a natural-order collector share the same stimulus.
module tb_fft_out_collector;
    import fft_out_collector_pkg::*;

    localparam int N  = FFT_N_PT;
    localparam int W  = FFT_SAMPLE_W;
    localparam int FW = N * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_out_collector_if #(.N_PT(N), .SAMPLE_W(W)) bi ();
    fft_out_collector_if #(.N_PT(N), .SAMPLE_W(W)) bn ();

    assign bn.in_valid  = bi.in_valid;
    assign bn.in_sof    = bi.in_sof;
    assign bn.in_data   = bi.in_data;
    assign bn.out_ready = bi.out_ready;

    fft_out_collector #(.N_PT(N), .SAMPLE_W(W), .BITREV(1'b1)) dut_br (
        .clk (clk),
        .rst (rst),
        .bus (bi.slave)
    );

    fft_out_collector #(.N_PT(N), .SAMPLE_W(W), .BITREV(1'b0)) dut_nr (
        .clk (clk),
        .rst (rst),
        .bus (bn.slave)
    );

    int chk = 0;
    int pass = 0;
    int hs_br = 0, hs_nr = 0;
    int se_br = 0, se_nr = 0;
    logic [FW-1:0] q_br [$];
    logic [FW-1:0] q_nr [$];
    logic [FW-1:0] e_br, e_nr;

    function automatic logic [W-1:0] smp(input int tag, input int k);
        sample_t s;
        s.re = 17'(tag * 16 + k);
        s.im = 17'(-(tag * 16 + k) - 1);
        return s;
    endfunction

    // Expected frame built independently: for 4 points, slot of sample k is {k[0],k[1]}.
    function automatic logic [FW-1:0] efrm(input int tag, input bit rev);
        logic [FW-1:0] f;
        int slot;
        f = '0;
        for (int k = 0; k < N; k++) begin
            slot = rev ? (((k & 1) << 1) | ((k >> 1) & 1)) : k;
            f[slot*W +: W] = smp(tag, k);
        end
        return f;
    endfunction

    task automatic push(input int tag);
        q_br.push_back(efrm(tag, 1'b1));
        q_nr.push_back(efrm(tag, 1'b0));
    endtask

    task automatic send(input logic sof, input logic [W-1:0] d);
        @(posedge clk);
        #1;
        bi.in_valid = 1'b1;
        bi.in_sof   = sof;
        bi.in_data  = d;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bi.in_valid = 1'b0;
        bi.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int tag, input bit sof_first);
        for (int k = 0; k < N; k++) begin
            send(sof_first && k == 0, smp(tag, k));
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && (q_br.size() != 0 || q_nr.size() != 0); i++) begin
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk++;
        if (q_br.size() != 0 || q_nr.size() != 0)
            $display("FAIL %s_drain: pending br=%0d nr=%0d, required 0/0", name, q_br.size(), q_nr.size());
        else pass++;
    endtask

    // Scoreboard: every handshake pops and compares the oldest expected frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (bi.out_valid === 1'b1 && bi.out_ready === 1'b1) begin
                hs_br++;
                chk++;
                if (q_br.size() == 0) begin
                    $display("FAIL frame_br: unexpected frame %h, none required", bi.out_frame);
                end else begin
                    e_br = q_br.pop_front();
                    if (bi.out_frame !== e_br) $display("FAIL frame_br: got %h required %h", bi.out_frame, e_br);
                    else pass++;
                end
            end
            if (bn.out_valid === 1'b1 && bn.out_ready === 1'b1) begin
                hs_nr++;
                chk++;
                if (q_nr.size() == 0) begin
                    $display("FAIL frame_nr: unexpected frame %h, none required", bn.out_frame);
                end else begin
                    e_nr = q_nr.pop_front();
                    if (bn.out_frame !== e_nr) $display("FAIL frame_nr: got %h required %h", bn.out_frame, e_nr);
                    else pass++;
                end
            end
            if (bi.sync_err === 1'b1) se_br++;
            if (bn.sync_err === 1'b1) se_nr++;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk++; if (bi.out_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", bi.out_valid); else pass++;
        chk++; if (bi.out_frame !== '0) $display("FAIL rst_frame: got %h required 0", bi.out_frame); else pass++;
        chk++; if (bi.sync_err !== 1'b0) $display("FAIL rst_sync_err: got %b required 0", bi.sync_err); else pass++;
        chk++; if (bi.overflow !== 1'b0) $display("FAIL rst_overflow: got %b required 0", bi.overflow); else pass++;
        chk++; if (bn.out_valid !== 1'b0) $display("FAIL rst_valid_nr: got %b required 0", bn.out_valid); else pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bi.out_ready = 1'b1;
        send(1'b0, smp(9, 0));
        send(1'b0, smp(9, 1));
        idle();
        push(1);
        send_frame(1, 1'b1);
        idle();
        @(negedge clk);
        chk++; if (bi.out_valid !== 1'b0) $display("FAIL lat_early: out_valid %b required 0", bi.out_valid); else pass++;
        @(negedge clk);
        chk++; if (bi.out_valid !== 1'b1) $display("FAIL lat: out_valid %b required 1", bi.out_valid); else pass++;
        chk++; if (bn.out_valid !== 1'b1) $display("FAIL lat_nr: out_valid %b required 1", bn.out_valid); else pass++;
        chk++; if (bi.sync_err !== 1'b0) $display("FAIL basic_sync_err: got %b required 0", bi.sync_err); else pass++;
        wait_drain("basic");
    endtask

    task automatic test_resync();
        bi.out_ready = 1'b1;
        se_br = 0;
        se_nr = 0;
        push(3);
        send(1'b1, smp(2, 0));
        send(1'b0, smp(2, 1));
        send_frame(3, 1'b1);
        idle();
        wait_drain("resync");
        chk++; if (se_br != 1) $display("FAIL resync_pulses: got %0d required 1", se_br); else pass++;
        chk++; if (se_nr != 1) $display("FAIL resync_pulses_nr: got %0d required 1", se_nr); else pass++;
    endtask

    task automatic test_continuous();
        int h0;
        bi.out_ready = 1'b1;
        h0 = hs_br;
        for (int f = 0; f < 8; f++) push(10 + f);
        for (int f = 0; f < 8; f++) send_frame(10 + f, f == 0);
        idle();
        wait_drain("cont");
        chk++; if (hs_br - h0 != 8) $display("FAIL cont_handshakes: got %0d required 8", hs_br - h0); else pass++;
        chk++; if (bi.overflow !== 1'b0) $display("FAIL cont_overflow: got %b required 0", bi.overflow); else pass++;
        chk++; if (bn.overflow !== 1'b0) $display("FAIL cont_overflow_nr: got %b required 0", bn.overflow); else pass++;
    endtask

    task automatic test_overflow();
        bi.out_ready = 1'b0;
        push(20);
        push(21);
        send_frame(20, 1'b1);
        send_frame(21, 1'b0);
        idle();
        @(negedge clk);
        chk++; if (bi.overflow !== 1'b0) $display("FAIL ovf_pre: got %b required 0", bi.overflow); else pass++;
        chk++; if (bi.out_valid !== 1'b1) $display("FAIL stall_valid: got %b required 1", bi.out_valid); else pass++;
        chk++; if (bi.out_frame !== q_br[0]) $display("FAIL stall_frame: got %h required %h", bi.out_frame, q_br[0]); else pass++;
        send(1'b0, smp(22, 0));
        idle();
        @(negedge clk);
        chk++; if (bi.overflow !== 1'b1) $display("FAIL ovf_set: got %b required 1", bi.overflow); else pass++;
        chk++; if (bn.overflow !== 1'b1) $display("FAIL ovf_set_nr: got %b required 1", bn.overflow); else pass++;
        for (int k = 1; k < N; k++) send(1'b0, smp(22, k));
        idle();
        repeat (2) @(negedge clk);
        chk++; if (bi.out_frame !== q_br[0]) $display("FAIL stall_hold: got %h required %h", bi.out_frame, q_br[0]); else pass++;
        @(posedge clk);
        #1;
        bi.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk++; if (bi.out_valid !== 1'b1) $display("FAIL b2b_valid: got %b required 1", bi.out_valid); else pass++;
        wait_drain("ovf_b2b");
        push(23);
        send_frame(23, 1'b1);
        idle();
        wait_drain("ovf_recover");
        chk++; if (bi.overflow !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", bi.overflow); else pass++;
    endtask

    task automatic test_reset_mid();
        bi.out_ready = 1'b1;
        send(1'b1, smp(30, 0));
        send(1'b0, smp(30, 1));
        @(posedge clk);
        #3;
        rst = 1'b1;
        bi.in_valid = 1'b0;
        bi.in_sof   = 1'b0;
        #1;
        chk++; if (bi.out_valid !== 1'b0) $display("FAIL arst_valid: got %b required 0", bi.out_valid); else pass++;
        chk++; if (bi.out_frame !== '0) $display("FAIL arst_frame: got %h required 0", bi.out_frame); else pass++;
        chk++; if (bi.overflow !== 1'b0) $display("FAIL arst_overflow: got %b required 0", bi.overflow); else pass++;
        chk++; if (bi.sync_err !== 1'b0) $display("FAIL arst_sync_err: got %b required 0", bi.sync_err); else pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        se_br = 0;
        push(31);
        send_frame(31, 1'b1);
        idle();
        wait_drain("arst");
        chk++; if (se_br != 0) $display("FAIL arst_no_sync_err: got %0d required 0", se_br); else pass++;
        chk++; if (bi.overflow !== 1'b0) $display("FAIL arst_overflow_after: got %b required 0", bi.overflow); else pass++;
    endtask

    initial begin
        bi.in_valid  = 1'b0;
        bi.in_sof    = 1'b0;
        bi.in_data   = '0;
        bi.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_resync();
        test_continuous();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
